// File: rtl/reg_wb_queue_pkg.sv
// Shared types and constants for the register-file writeback queue.
// Entries pair a destination register with its result data.
package reg_wb_queue_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int NUM_WB_LANES = 2;
  localparam int NUM_RD_LANES = 4;
  localparam int WB_DATA_W    = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/wb_bypass_match.sv
// One bypass lookup lane: scans the live queue entries oldest to youngest so the
// youngest matching entry's data wins. Register 0 never hits.
module wb_bypass_match
  import reg_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t                      entries_i [DEPTH],
  input  logic [DEPTH-1:0]               valid_i,
  input  logic [$clog2(DEPTH)-1:0]       head_i,
  input  logic [REG_ADDR_W-1:0]          addr_i,
  output logic                           hit_o,
  output logic [WB_DATA_W-1:0]           data_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx_s;

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx_s  = '0;
    for (int o = 0; o < DEPTH; o++) begin
      idx_s = head_i + PTR_W'(o);
      if ((addr_i != '0) && valid_i[idx_s] && (entries_i[idx_s].addr == addr_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx_s].data;
      end else begin
        hit_o  = hit_o;
      end
    end
  end

endmodule

// File: rtl/reg_wb_queue.sv
// In-order writeback queue feeding a 2-write-port register file, with a 4-lane
// bypass so reads observe results that are still waiting to be written.
module reg_wb_queue
  import reg_wb_queue_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_W,
  parameter int DEPTH      = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_WB_LANES-1:0]                    wb_valid_i,
  output logic [NUM_WB_LANES-1:0]                    wb_ready_o,
  input  logic [NUM_WB_LANES-1:0][REG_ADDR_W-1:0]    wb_addr_i,
  input  logic [NUM_WB_LANES-1:0][DATA_WIDTH-1:0]    wb_data_i,
  output logic [NUM_WB_LANES-1:0]                    w_en_o,
  output logic [NUM_WB_LANES-1:0][REG_ADDR_W-1:0]    w_addr_o,
  output logic [NUM_WB_LANES-1:0][DATA_WIDTH-1:0]    w_data_o,
  input  logic [NUM_RD_LANES-1:0][REG_ADDR_W-1:0]    r_addr_i,
  output logic [NUM_RD_LANES-1:0]                    byp_hit_o,
  output logic [NUM_RD_LANES-1:0][DATA_WIDTH-1:0]    byp_data_o,
  output logic                                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];

  logic [NUM_WB_LANES-1:0] ready_s, fire_s, enq_s, w_en_s;
  logic [CNT_W-1:0]        n_enq_s, n_deq_s;
  wb_entry_t               ent0_s, ent1_s;
  logic [DEPTH-1:0]        valid_s;

  logic [NUM_RD_LANES-1:0]                  hit_s;
  logic [NUM_RD_LANES-1:0][WB_DATA_W-1:0]   match_data_s;

  // Ready only looks at the occupancy at cycle start; same-cycle drains earn no credit.
  always_comb begin
    ready_s[0] = ~rst && (count_q <= CNT_W'(DEPTH - 1));
    ready_s[1] = ~rst && (count_q <= CNT_W'(DEPTH - 2));
    fire_s     = wb_valid_i & ready_s;
    for (int l = 0; l < NUM_WB_LANES; l++) begin
      enq_s[l] = fire_s[l] && (wb_addr_i[l] != '0);
    end
    n_enq_s = CNT_W'(enq_s[0]) + CNT_W'(enq_s[1]);
  end

  // Two oldest entries drain together unless they target the same register.
  always_comb begin
    ent0_s    = mem_q[head_q];
    ent1_s    = mem_q[head_q + PTR_W'(1)];
    w_en_s[0] = ~rst && (count_q != '0);
    w_en_s[1] = ~rst && (count_q >= CNT_W'(2)) && (ent0_s.addr != ent1_s.addr);
    n_deq_s   = CNT_W'(w_en_s[0]) + CNT_W'(w_en_s[1]);
  end

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d  = mem_q;
    tail_d = tail_q;
    for (int l = 0; l < NUM_WB_LANES; l++) begin
      if (enq_s[l]) begin
        mem_d[tail_d].addr = wb_addr_i[l];
        mem_d[tail_d].data = wb_data_i[l];
        tail_d             = tail_d + PTR_W'(1);
      end else begin
        tail_d = tail_d;
      end
    end
    head_d  = head_q + PTR_W'(n_deq_s);
    count_d = count_q + n_enq_s - n_deq_s;
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payloads carry no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Live-entry mask: offset from head below count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_s[i] = {1'b0, PTR_W'(PTR_W'(i) - head_q)} < count_q;
    end
  end

  for (genvar k = 0; k < NUM_RD_LANES; k++) begin : g_byp
    wb_bypass_match #(.DEPTH(DEPTH)) u_match (
      .entries_i (mem_q),
      .valid_i   (valid_s),
      .head_i    (head_q),
      .addr_i    (r_addr_i[k]),
      .hit_o     (hit_s[k]),
      .data_o    (match_data_s[k])
    );
  end

  // Output drive, forced idle while reset is asserted.
  always_comb begin
    wb_ready_o  = ready_s;
    w_en_o      = w_en_s;
    w_addr_o[0] = ent0_s.addr;
    w_addr_o[1] = ent1_s.addr;
    w_data_o[0] = ent0_s.data;
    w_data_o[1] = ent1_s.data;
    for (int k = 0; k < NUM_RD_LANES; k++) begin
      byp_hit_o[k]  = ~rst && hit_s[k];
      byp_data_o[k] = byp_hit_o[k] ? match_data_s[k] : '0;
    end
    empty_o = rst || (count_q == '0);
  end

endmodule
